// File: rtl/spike_rate_encoder_if.sv
// Load/seed/start inputs and spike-vector outputs of the rate encoder.
interface spike_rate_encoder_if #(
    parameter int N_STAGES = 5,
    parameter int INPUTS   = 2 ** N_STAGES
);
    logic [7:0]          data_in;
    logic                load_valid;
    logic [N_STAGES-1:0] load_addr;
    logic                seed_load;
    logic                start;
    logic                ready;
    logic [INPUTS-1:0]   spikes;
    logic                spikes_valid;

    modport master (
        output data_in, load_valid, load_addr, seed_load, start,
        input  ready, spikes, spikes_valid
    );

    modport slave (
        input  data_in, load_valid, load_addr, seed_load, start,
        output ready, spikes, spikes_valid
    );
endinterface

// File: rtl/spike_rate_encoder.sv
// Bernoulli rate encoder: one channel per cycle compared against a shared
// 16-bit Galois LFSR, producing a registered spike vector with a valid pulse.
module spike_rate_encoder #(
    parameter int          N_STAGES   = 5,
    parameter int          INPUTS     = 2 ** N_STAGES,
    parameter int          VALUE_BITS = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic                 clk,
    input logic                 reset,
    spike_rate_encoder_if.slave bus
);
    typedef enum logic {StIdle, StGen} state_e;

    localparam logic [15:0]         TapMask = 16'hB400;
    localparam logic [N_STAGES-1:0] LastCh  = N_STAGES'(INPUTS - 1);

    state_e                state_q, state_d;
    logic [N_STAGES-1:0]   ch_q, ch_d;
    logic [INPUTS-1:0]     acc_q, acc_d;
    logic [15:0]           lfsr_q, lfsr_d;
    logic [INPUTS-1:0]     spikes_q, spikes_d;
    logic                  spikes_valid_q, spikes_valid_d;
    logic [VALUE_BITS-1:0] intensity_q [INPUTS];

    logic        bit_now;
    logic [15:0] lfsr_step;

    // Compare uses the pre-step LFSR and the registered (old) intensity.
    assign bit_now   = intensity_q[ch_q] > lfsr_q[VALUE_BITS-1:0];
    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TapMask : 16'h0000);

    assign bus.ready        = (state_q == StIdle);
    assign bus.spikes       = spikes_q;
    assign bus.spikes_valid = spikes_valid_q;

    // Intensity store: writable in any state, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < INPUTS; i++) begin
                intensity_q[i] <= '0;
            end
        end else if (bus.load_valid) begin
            intensity_q[bus.load_addr] <= bus.data_in;
        end
    end

    // Next-state: IDLE accepts seed/start, GEN evaluates one channel per cycle.
    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        acc_d          = acc_q;
        lfsr_d         = lfsr_q;
        spikes_d       = spikes_q;
        spikes_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Seed lands on the same edge as start, so GEN begins from it.
                if (bus.seed_load) begin
                    lfsr_d = {bus.data_in, ~bus.data_in};
                end
                if (bus.start) begin
                    state_d = StGen;
                    ch_d    = '0;
                end
            end
            StGen: begin
                acc_d[ch_q] = bit_now;
                lfsr_d      = lfsr_step;
                ch_d        = ch_q + N_STAGES'(1);
                if (ch_q == LastCh) begin
                    spikes_d       = acc_d;
                    spikes_valid_d = 1'b1;
                    acc_d          = '0;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset discards any partially built vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            ch_q           <= '0;
            acc_q          <= '0;
            lfsr_q         <= LFSR_SEED;
            spikes_q       <= '0;
            spikes_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            acc_q          <= acc_d;
            lfsr_q         <= lfsr_d;
            spikes_q       <= spikes_d;
            spikes_valid_q <= spikes_valid_d;
        end
    end
endmodule

// File: tb/tb_spike_rate_encoder.sv
// Scoreboard bench for spike_rate_encoder: expected vectors are queued at
// start time and a negedge monitor pops and compares on each valid pulse.
module tb_spike_rate_encoder;
    localparam int          NS   = 5;
    localparam int          NI   = 32;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   total_spikes = 0;

    logic [31:0] exp_q[$];
    logic [15:0] m_lfsr;
    logic [7:0]  m_int [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spike_rate_encoder_if #(.N_STAGES(NS), .INPUTS(NI)) bus ();

    spike_rate_encoder #(
        .N_STAGES  (NS),
        .INPUTS    (NI),
        .VALUE_BITS(8),
        .LFSR_SEED (SEED)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one timestep from the current model LFSR and intensities.
    function automatic logic [31:0] model_ts();
        logic [31:0] v;
        for (int i = 0; i < NI; i++) begin
            v[i]   = m_int[i] > m_lfsr[7:0];
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
        return v;
    endfunction

    // Monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [31:0] e;
        if (bus.spikes_valid) begin
            total_spikes += $countones(bus.spikes);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("spikes", bus.spikes, e);
            end
        end
    end

    task automatic load(input int a, input logic [7:0] v);
        bus.load_valid = 1'b1;
        bus.load_addr  = NS'(a);
        bus.data_in    = v;
        @(negedge clk);
        bus.load_valid = 1'b0;
        m_int[a]       = v;
    endtask

    task automatic load_all(input logic [7:0] v);
        for (int i = 0; i < NI; i++) load(i, v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        m_lfsr = SEED;
        for (int i = 0; i < NI; i++) m_int[i] = 8'h00;
    endtask

    // Called at a negedge; returns at the negedge where the pulse is seen.
    // mode 1: mid-GEN writes/start/seed; mode 2: reset at E+10.
    task automatic run_ts(input int mode, input bit do_seed, input logic [7:0] seed,
                          output int lat, output int low, output int pcyc);
        int e;
        bus.start = 1'b1;
        if (do_seed) begin
            bus.seed_load = 1'b1;
            bus.data_in   = seed;
        end
        @(negedge clk);
        bus.start     = 1'b0;
        bus.seed_load = 1'b0;
        e    = cyc;
        low  = 0;
        lat  = -1;
        pcyc = -1;
        for (int k = 0; k < 40; k++) begin
            if (!bus.ready) low++;
            if (bus.spikes_valid) begin
                lat  = cyc - e;
                pcyc = cyc;
                break;
            end
            bus.load_valid = 1'b0;
            bus.start      = 1'b0;
            bus.seed_load  = 1'b0;
            reset          = 1'b0;
            if (mode == 1 && cyc == e + 4) begin
                bus.load_valid = 1'b1;
                bus.load_addr  = NS'(31);
                bus.data_in    = 8'hFF;
            end
            if (mode == 1 && cyc == e + 5) begin
                bus.load_valid = 1'b1;
                bus.load_addr  = NS'(0);
                bus.data_in    = 8'hFF;
                bus.start      = 1'b1;
                bus.seed_load  = 1'b1;
            end
            if (mode == 2 && cyc == e + 9) reset = 1'b1;
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
        bus.start      = 1'b0;
        bus.seed_load  = 1'b0;
        reset          = 1'b0;
    endtask

    initial begin
        int          lat, low, pcyc, prev;
        logic [31:0] exp_full;
        logic [31:0] e;

        reset          = 1'b1;
        bus.data_in    = 8'h00;
        bus.load_valid = 1'b0;
        bus.load_addr  = '0;
        bus.seed_load  = 1'b0;
        bus.start      = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();

        check("reset_ready", 32'(bus.ready), 32'd1);
        check("reset_spikes", bus.spikes, 32'h0);
        check("reset_valid", 32'(bus.spikes_valid), 32'd0);

        // All-zero intensities: exactly 32 cycles to the pulse, empty vector.
        e = model_ts();
        exp_q.push_back(32'h0);
        run_ts(0, 1'b0, 8'h00, lat, low, pcyc);
        check("zero_latency", 32'(lat), 32'd32);
        check("zero_ready_low", 32'(low), 32'd32);
        check("zero_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));

        // Full intensity from the default seed.
        do_reset();
        load_all(8'hFF);
        exp_full = model_ts();
        exp_q.push_back(exp_full);
        run_ts(0, 1'b0, 8'h00, lat, low, pcyc);
        check("full_latency", 32'(lat), 32'd32);
        check("full_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));

        // Seeded ramp, seed and start in the same IDLE cycle, 4 back-to-back.
        for (int i = 0; i < NI; i++) load(i, 8'(8 * i));
        m_lfsr = 16'h5AA5;
        prev   = -1;
        for (int t = 0; t < 4; t++) begin
            exp_q.push_back(model_ts());
            run_ts(0, t == 0, 8'h5A, lat, low, pcyc);
            check("seed_latency", 32'(lat), 32'd32);
            check("seed_ready_low", 32'(low), 32'd32);
            if (t > 0) check("seed_spacing", 32'(pcyc - prev), 32'd33);
            prev = pcyc;
        end
        check("seed_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));

        // Busy: ch31 write visible now, ch0 write deferred, start/seed ignored.
        m_int[31] = 8'hFF;
        exp_q.push_back(model_ts());
        run_ts(1, 1'b0, 8'h00, lat, low, pcyc);
        m_int[0] = 8'hFF;
        check("busy_latency", 32'(lat), 32'd32);
        check("busy_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
        repeat (3) @(negedge clk);
        check("busy_no_extra", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(model_ts());
        run_ts(0, 1'b0, 8'h00, lat, low, pcyc);
        check("after_busy_latency", 32'(lat), 32'd32);

        // Reset at E+10: no pulse, then default-seed sequence repeats.
        run_ts(2, 1'b0, 8'h00, lat, low, pcyc);
        check("reset_mid_no_pulse", 32'(lat), 32'hFFFF_FFFF);
        m_lfsr = SEED;
        for (int i = 0; i < NI; i++) m_int[i] = 8'h00;
        check("reset_mid_spikes", bus.spikes, 32'h0);
        load_all(8'hFF);
        e = model_ts();
        exp_q.push_back(exp_full);
        run_ts(0, 1'b0, 8'h00, lat, low, pcyc);
        check("reset_mid_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));

        // Statistics at intensity 128.
        load_all(8'h80);
        total_spikes = 0;
        for (int t = 0; t < 256; t++) begin
            exp_q.push_back(model_ts());
            run_ts(0, 1'b0, 8'h00, lat, low, pcyc);
        end
        @(negedge clk);
        checks++;
        if (total_spikes < 3900 || total_spikes > 4300) begin
            errors++;
            $display("FAIL stats_128: got %0d expected 3900..4300", total_spikes);
        end

        // Intensity 0 never spikes.
        load_all(8'h00);
        total_spikes = 0;
        for (int t = 0; t < 8; t++) begin
            exp_q.push_back(model_ts());
            run_ts(0, 1'b0, 8'h00, lat, low, pcyc);
        end
        @(negedge clk);
        check("stats_zero", 32'(total_spikes), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

Upstream stage for the LIF/PWM neuron core. It holds one 8-bit intensity per synapse and, on each `start`, produces a Bernoulli rate-coded spike vector of width `INPUTS`. Each bit is generated by comparing the channel intensity with a shared 16-bit LFSR, one channel per cycle. The resulting vector is presented as a registered word with a one-cycle valid pulse, ready to be written into the neuron's `inputs` register in place of host-streamed bytes.

## Interface
Parameters:
- `N_STAGES`, 5: log2 of the channel count; must match the neuron core.
- `INPUTS`, 2**`N_STAGES`: number of channels and the spike-vector width.
- `VALUE_BITS`, 8: intensity width; fixed at 8 by the byte load path.
- `LFSR_SEED`, 16'hACE1: LFSR value after reset; must be nonzero.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `data_in` in 8: intensity byte or seed byte.
- `load_valid` in 1: writes `data_in` to `intensity[load_addr]` on this edge.
- `load_addr` in `N_STAGES`: channel index for `load_valid`.
- `seed_load` in 1: reseeds the LFSR; honoured only in IDLE.
- `start` in 1: requests one timestep; honoured only in IDLE.
- `ready` out 1: high in IDLE.
- `spikes` out `INPUTS`: registered spike vector; bit i belongs to channel i.
- `spikes_valid` out 1: one-cycle pulse when `spikes` is updated.

## Operation
- Storage: `INPUTS` x 8-bit intensity registers.
- LFSR: 16-bit Galois, right-shifting, tap mask 16'hB400.
  - Step rule: `lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0)`.
  - Advances exactly once per GEN cycle and never in IDLE.
- Seeding: `seed_load` in IDLE sets `lfsr <= {data_in, ~data_in}`, which is never zero.
- FSM has two states:
  - IDLE: `ready`=1. `start` moves to GEN with `ch`=0.
  - GEN: `ready`=0. Each cycle evaluates channel `ch`:
    - Rule: `bit = intensity[ch] > lfsr[7:0]`, unsigned, using the pre-step LFSR value.
    - The bit is written to position `ch` of an internal accumulator; then `ch` increments.
    - When `ch` = `INPUTS`-1: the accumulator with the final bit is loaded into `spikes`, `spikes_valid` pulses, and the FSM returns to IDLE.
- Spike probability per channel is intensity/256:
  - Intensity 0 never spikes.
  - Intensity 255 spikes unless `lfsr[7:0]` = 8'hFF.
- `spikes` holds its previous value throughout GEN and changes only on completion.
- Boundary rules:
  - `start` or `seed_load` during GEN: ignored, with no queuing.
  - `seed_load` and `start` in the same IDLE cycle: the seed is loaded, and generation begins from the new seed.
  - `load_valid` is accepted in any state.
    - A write to a channel not yet evaluated in the current GEN affects this timestep.
    - A write to an already-evaluated channel, or to the channel evaluated in the same cycle, affects the next timestep. Reads see the old value.
  - `load_valid` and `start` in the same IDLE cycle: the write lands first, so channel 0 sees the new value.
  - `ch` wraps from `INPUTS`-1 back to 0 on exit, ready for the next timestep.
- `reset`, including mid-GEN, produces:
  - State: FSM in IDLE, `ch`=0, accumulator 0, all intensities 0.
  - LFSR: `LFSR_SEED`.
  - Outputs: `spikes`=0, `spikes_valid`=0, `ready`=1.
  - Any partially built vector is discarded and no valid pulse is emitted.

## Timing
- `start` is sampled at edge E in IDLE.
  - `ready` is low during cycles E+1 .. E+`INPUTS`.
  - Channel i is evaluated at edge E+1+i.
- At edge E+`INPUTS`, `spikes` is updated and `spikes_valid` rises for one cycle.
  - `ready` is high in the same cycle, so a back-to-back `start` is legal.
  - Throughput is one vector per `INPUTS`+1 cycles (33 at default).
- Load and seed writes take effect at the edge they are sampled; no read-after-write bypass.
- All outputs are registered except `ready`, which is decoded directly from the state register.

## Test plan
- Reset values: after reset check `ready`=1, `spikes`=0, `spikes_valid`=0. Start with all intensities 0: the pulse arrives exactly 32 cycles after the start edge, with `spikes`=32'h0.
- Full intensity with default seed: load 255 on all channels and start. `spikes` must equal a bit-accurate model using `LFSR_SEED` and 16'hB400. The LFSR must equal the model state after exactly 32 steps.
- Seeded pattern:
  - Stimulus: `seed_load` with 8'h5A; intensity[i] = 8*i; run 4 back-to-back timesteps.
  - Response: each vector matches the model.
  - Timing: `spikes_valid` pulses 33 cycles apart; `ready` is low for exactly 32 cycles each time.
- Busy rules: `start` and `seed_load` asserted mid-GEN produce no extra pulse and no LFSR disturbance. A write of 255 to channel 31 at cycle E+5 is visible in the same vector; a write to channel 0 at E+5 is not.
- Reset mid-GEN: reset at E+10 gives no pulse. The next start reproduces the default-seed sequence from the full-intensity scenario.
- Statistics: intensity 128 on all channels over 256 timesteps gives a total spike count in [3900, 4300] of 8192. Intensity 0 gives exactly 0.
